// File: rtl/uart_stream_tx.sv
// UART transmitter fed by a small FIFO: words queued on a valid/ready input
// are serialised as start, LSB-first data, optional parity and stop bits.
module uart_stream_tx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 2,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          tx_en,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 push, pop;

  state_t               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 start_ok, last_clk;

  assign in_ready   = (count_q < CNTW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign start_ok   = (count_q != '0) && tx_en;
  assign last_clk   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Frame sequencing; the bit-period counter restarts on every bit and state entry
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    idx_d     = idx_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (start_ok) begin
          state_d = S_START;
          pop     = 1'b1;
        end
      end
      S_START: begin
        if (last_clk) begin
          state_d   = S_DATA;
          clk_cnt_d = '0;
          idx_d     = '0;
        end
      end
      S_DATA: begin
        if (last_clk) begin
          clk_cnt_d = '0;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (last_clk) begin
          state_d   = S_STOP;
          clk_cnt_d = '0;
          idx_d     = '0;
        end
      end
      S_STOP: begin
        if (last_clk) begin
          clk_cnt_d = '0;
          if (idx_q == IW'(STOP_BITS - 1)) begin
            idx_d = '0;
            if (start_ok) begin
              state_d = S_START;
              pop     = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        idx_d     = '0;
      end
    endcase
  end

  // Line value is registered from the next state so tx never glitches
  always_comb begin
    shreg_d = pop ? mem_q[rd_ptr_q] : shreg_q;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[idx_d];
      S_PARITY: tx_d = parity_bit(shreg_d);
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_stream_tx.sv
// Bench for uart_stream_tx: three instances (no parity, even, odd) share one
// clock and reset; a serial-line monitor decodes frames against a queue.
module tb_uart_stream_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] in_data [3];
  logic [2:0] in_valid;
  logic [2:0] tx_en;
  wire  [2:0] in_ready;
  wire  [2:0] tx;
  wire  [2:0] busy;
  wire  [2:0] fifo_count [3];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         lane;
    logic [7:0] data;
    logic       par;
  } exp_t;
  exp_t exp_q[$];

  localparam int PAR_MODE [3] = '{0, 2, 1};

  always #5 clk = ~clk;

  uart_stream_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4)) u_plain (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .tx_en(tx_en[0]), .tx(tx[0]), .busy(busy[0]), .fifo_count(fifo_count[0]));

  uart_stream_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .tx_en(tx_en[1]), .tx(tx[1]), .busy(busy[1]), .fifo_count(fifo_count[1]));

  uart_stream_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .tx_en(tx_en[2]), .tx(tx[2]), .busy(busy[2]), .fifo_count(fifo_count[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int lane, input logic [7:0] d, input logic p);
    exp_t e;
    @(negedge clk);
    in_data[lane]  = d;
    in_valid[lane] = 1'b1;
    e.lane = lane;
    e.data = d;
    e.par  = p;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid[lane] = 1'b0;
  endtask

  task automatic busy_width(input int lane, output int width);
    int t;
    t = 0;
    width = 0;
    while (!busy[lane] && t < 100) begin
      @(negedge clk);
      t++;
    end
    while (busy[lane] && width < 1000) begin
      @(negedge clk);
      width++;
    end
  endtask

  // Serial monitor: samples mid-bit, pops the expected word at the last stop bit
  initial begin : monitor
    int         cyc  [3];
    bit         act  [3];
    bit         prev [3];
    logic [10:0] bits [3];
    int         k, nb;
    exp_t       e;
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 0; act[i] = 1'b0; prev[i] = 1'b1; bits[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        nb = (PAR_MODE[i] != 0) ? 11 : 10;
        if (rst) begin
          act[i]  = 1'b0;
          prev[i] = 1'b1;
        end else begin
          if (!act[i] && prev[i] && !tx[i]) begin
            act[i] = 1'b1;
            cyc[i] = 0;
          end else if (act[i]) begin
            cyc[i]++;
          end
          if (act[i] && (cyc[i] % 4) == 2) begin
            k = cyc[i] / 4;
            bits[i][k] = tx[i];
            if (k == nb - 1) begin
              act[i] = 1'b0;
              if (exp_q.size() == 0) begin
                check("frame_unexpected", exp_q.size(), 1);
              end else begin
                e = exp_q.pop_front();
                check("frame_lane", i, e.lane);
                check("frame_data", bits[i][8:1], e.data);
                if (nb == 11) check("frame_parity", bits[i][9], e.par);
                check("frame_start_stop", {bits[i][0], bits[i][nb-1]}, 2'b01);
              end
            end
          end
          prev[i] = tx[i];
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int   w, hi, lo;
    exp_t e;
    in_valid = '0;
    tx_en    = 3'b110;
    for (int i = 0; i < 3; i++) in_data[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 3'b111);
    check("reset_busy", busy, 3'b000);
    check("reset_count", fifo_count[0], 0);
    check("reset_in_ready", in_ready, 3'b111);
    rst = 1'b0;

    // single frame 0x55
    tx_en[0] = 1'b1;
    push(0, 8'h55, 1'b0);
    busy_width(0, w);
    check("single_busy_cycles", w, 40);

    // parity lanes
    push(1, 8'h07, 1'b1);
    busy_width(1, w);
    check("even_busy_cycles", w, 44);
    push(2, 8'h07, 1'b0);
    busy_width(2, w);
    check("odd_busy_cycles", w, 44);

    // fill past full, then drain back-to-back
    tx_en[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_data[0] = 8'(8'hA1 + j);
      if (j < 4) begin
        e.lane = 0; e.data = 8'(8'hA1 + j); e.par = 1'b0;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    check("full_in_ready", in_ready[0], 1'b0);
    check("full_count", fifo_count[0], 4);
    check("full_busy", busy[0], 1'b0);
    tx_en[0] = 1'b1;
    busy_width(0, w);
    check("burst_busy_cycles", w, 160);
    check("burst_count_end", fifo_count[0], 0);

    // pause mid-frame
    tx_en[0] = 1'b0;
    push(0, 8'hB1, 1'b0);
    push(0, 8'hB2, 1'b0);
    push(0, 8'hB3, 1'b0);
    tx_en[0] = 1'b1;
    for (int t = 0; t < 100 && !busy[0]; t++) @(negedge clk);
    repeat (8) @(negedge clk);
    tx_en[0] = 1'b0;
    for (int t = 0; t < 200 && busy[0]; t++) @(negedge clk);
    hi = 0; lo = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy[0]) hi++;
      if (!tx[0]) lo++;
    end
    check("pause_busy_samples", hi, 0);
    check("pause_tx_low_samples", lo, 0);
    check("pause_count", fifo_count[0], 2);
    tx_en[0] = 1'b1;
    busy_width(0, w);
    check("resume_busy_cycles", w, 80);
    check("resume_count_end", fifo_count[0], 0);

    // reset during data bit 3
    tx_en[0] = 1'b0;
    push(0, 8'hC1, 1'b0);
    push(0, 8'hC2, 1'b0);
    push(0, 8'hC3, 1'b0);
    tx_en[0] = 1'b1;
    for (int t = 0; t < 100 && !busy[0]; t++) @(negedge clk);
    repeat (17) @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async_tx", tx[0], 1'b1);
    check("rst_async_busy", busy[0], 1'b0);
    check("rst_async_count", fifo_count[0], 0);
    check("rst_async_in_ready", in_ready[0], 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hi = 0; lo = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy[0]) hi++;
      if (!tx[0]) lo++;
    end
    check("post_rst_busy_samples", hi, 0);
    check("post_rst_tx_low_samples", lo, 0);
    push(0, 8'h3C, 1'b0);
    busy_width(0, w);
    check("post_rst_busy_cycles", w, 40);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
